// File: rtl/gmii_tx_arbiter.sv
// -----------------------------------------------------------------------------
// gmii_tx_arbiter
//
// Two clients share one GMII transmit path. When the path is free (state IDLE
// and the PCS is not busy), one requesting client is granted. The block then
// emits PREAMBLE_LEN bytes of 0x55 and the 0xD5 SFD, and streams the client's
// bytes until the client marks the last byte. If the client fails to supply a
// byte while in DATA, the frame is aborted with a single TX_ER cycle. Every
// frame is followed by IPG_CYCLES idle cycles.
//
// Arbitration between simultaneous requests is round-robin: the client not
// granted most recently wins, and client 0 has priority after reset. Define
// GMII_TX_ARB_STRICT_PRIO_EN to use fixed priority instead: client 0 always
// wins, and the round-robin pointer is removed.
//
// Parameters
//   PREAMBLE_LEN   number of 0x55 preamble bytes sent before the SFD
//   IPG_CYCLES     number of idle cycles (TX_EN=0) spent in IPG after a frame
//
// Ports
//   GTX_CLK        transmit clock; all state changes on its rising edge
//   mr_main_reset  asynchronous, active-low reset
//   req0/req1      client requests to send a frame
//   vld0/vld1      client byte on data0/data1 is valid
//   data0/data1    client frame bytes (destination address onward)
//   last0/last1    marks the final byte of the frame (qualified by vldN)
//   transmitting   PCS busy flag; sampled only in IDLE
//   gnt0/gnt1      client owns the transmit path (registered, one-hot or zero)
//   rdy0/rdy1      client byte accepted this cycle (gntN AND state == DATA)
//   TXD/TX_EN/TX_ER  registered GMII transmit outputs
// -----------------------------------------------------------------------------
module gmii_tx_arbiter #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IPG_CYCLES   = 12
) (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       vld0,
    input  logic       vld1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       last0,
    input  logic       last1,
    input  logic       transmitting,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rdy0,
    output logic       rdy1,
    output logic [7:0] TXD,
    output logic       TX_EN,
    output logic       TX_ER
);

    localparam int CNT_MAX = (PREAMBLE_LEN > IPG_CYCLES) ? PREAMBLE_LEN : IPG_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_CYCLES - 1);

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        IPG
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifndef GMII_TX_ARB_STRICT_PRIO_EN
    // Client that wins the next simultaneous request.
    logic             rr_ptr;
`endif

    logic             any_req;
    logic             win;       // 0 = client 0, 1 = client 1
    logic             cur_vld;
    logic             cur_last;
    logic [7:0]       cur_data;

    assign any_req = req0 | req1;

    always_comb begin
`ifdef GMII_TX_ARB_STRICT_PRIO_EN
        win = ~req0;
`else
        // A lone requester always wins; a tie goes to the pointer.
        win = (req0 && req1) ? rr_ptr : req1;
`endif
    end

    // The granted client's byte stream; gnt1 alone is enough to select since
    // the grants are never both set.
    always_comb begin
        cur_vld  = gnt1 ? vld1  : vld0;
        cur_last = gnt1 ? last1 : last0;
        cur_data = gnt1 ? data1 : data0;
    end

    assign rdy0 = gnt0 && (state == DATA);
    assign rdy1 = gnt1 && (state == DATA);

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            TXD    <= 8'h00;
            TX_EN  <= 1'b0;
            TX_ER  <= 1'b0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
`ifndef GMII_TX_ARB_STRICT_PRIO_EN
            rr_ptr <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    TXD   <= 8'h00;
                    TX_EN <= 1'b0;
                    TX_ER <= 1'b0;
                    cnt   <= '0;
                    if (any_req && !transmitting) begin
                        gnt0   <= ~win;
                        gnt1   <= win;
`ifndef GMII_TX_ARB_STRICT_PRIO_EN
                        rr_ptr <= ~win;
`endif
                        state  <= PREAMBLE;
                    end
                end

                PREAMBLE: begin
                    TXD   <= PRE_BYTE;
                    TX_EN <= 1'b1;
                    TX_ER <= 1'b0;
                    if (cnt == PRE_LAST) begin
                        cnt   <= '0;
                        state <= SFD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SFD: begin
                    TXD   <= SFD_BYTE;
                    TX_EN <= 1'b1;
                    TX_ER <= 1'b0;
                    cnt   <= '0;
                    state <= DATA;
                end

                DATA: begin
                    TX_EN <= 1'b1;
                    if (cur_vld) begin
                        TXD   <= cur_data;
                        TX_ER <= 1'b0;
                        if (cur_last) begin
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                            cnt   <= '0;
                            state <= IPG;
                        end
                    end else begin
                        // Client ran dry mid-frame: poison the frame and stop.
                        TXD   <= 8'h00;
                        TX_ER <= 1'b1;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        cnt   <= '0;
                        state <= IPG;
                    end
                end

                IPG: begin
                    TXD   <= 8'h00;
                    TX_EN <= 1'b0;
                    TX_ER <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    if (cnt == IPG_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    TXD   <= 8'h00;
                    TX_EN <= 1'b0;
                    TX_ER <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
